// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and widths for the instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int OPC_W   = 6;
    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int ENTRY_W = ADDR_W + 2 * WORD_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DATA = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] word0;
        logic [WORD_W-1:0] word1;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Small prefetch FIFO with synchronous flush and occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch
// Brief  : Two-word instruction fetch from a handshaked ROM into a prefetch FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_cs,
    output logic [15:0] rom_addr,
    input  logic        rom_ready,
    input  logic [15:0] rom_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_word0,
    output logic [15:0] instr_word1,
    output logic [15:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state;
    logic              half;
    logic              discard;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [WORD_W-1:0] word0;
    logic              capture;
    logic              push;
    logic              pop;
    logic              slot_free;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign capture = (state == S_WAIT_DATA) && rom_ready;
    assign push    = capture && half && !discard && !redirect_valid;
    assign pop     = instr_valid && instr_ready && !redirect_valid;
    assign pc_next = redirect_valid ? redirect_pc : (push ? pc + 16'd2 : pc);

    // A slot stays reserved for the whole time the FSM is out of IDLE, so a
    // new fetch may start only if the FIFO still has room after this edge.
    assign slot_free = redirect_valid || pop ||
                       (push ? (count < CNT_W'(FIFO_DEPTH - 1)) : !fifo_full);

    assign push_entry = '{pc: pc, word0: word0, word1: rom_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            half     <= 1'b0;
            discard  <= 1'b0;
            pc       <= RESET_PC;
            word0    <= '0;
            rom_cs   <= 1'b0;
            rom_addr <= RESET_PC;
        end else begin
            rom_cs <= 1'b0;
            pc     <= pc_next;
            case (state)
                S_IDLE: begin
                    if (slot_free) begin
                        state    <= S_REQ;
                        half     <= 1'b0;
                        rom_cs   <= 1'b1;
                        rom_addr <= pc_next;
                    end
                end
                S_REQ: begin
                    state   <= S_WAIT_BUSY;
                    discard <= discard | redirect_valid;
                end
                S_WAIT_BUSY: begin
                    discard <= discard | redirect_valid;
                    // The idle-high ready must not be mistaken for data.
                    if (!rom_ready) begin
                        state <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (!rom_ready) begin
                        discard <= discard | redirect_valid;
                    end else begin
                        discard <= 1'b0;
                        if (!half && !discard && !redirect_valid) begin
                            word0    <= rom_data;
                            half     <= 1'b1;
                            state    <= S_REQ;
                            rom_cs   <= 1'b1;
                            rom_addr <= rom_addr + 16'd1;
                        end else if (slot_free) begin
                            state    <= S_REQ;
                            half     <= 1'b0;
                            rom_cs   <= 1'b1;
                            rom_addr <= pc_next;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign instr_valid = !fifo_empty;
    assign instr_pc    = head_entry.pc;
    assign instr_word0 = head_entry.word0;
    assign instr_word1 = head_entry.word1;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Directed and randomized bench for instr_fetch with a ROM model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_cs;
    logic [15:0] rom_addr;
    logic        rom_ready;
    logic [15:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word0;
    logic [15:0] instr_word1;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] mem [0:4095];
    int          phase = 0;
    logic [11:0] rom_a = '0;

    instr_fetch #(
        .RESET_PC   (16'h0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_cs         (rom_cs),
        .rom_addr       (rom_addr),
        .rom_ready      (rom_ready),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_word0    (instr_word0),
        .instr_word1    (instr_word1),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ROM: busy the cycle after cs, data the cycle after that, then idle.
    assign rom_ready = (phase != 1);
    assign rom_data  = (phase == 2) ? mem[rom_a] : 16'hzzzz;

    always @(posedge clk) begin
        if (rom_cs && !rst) begin
            chk("rom_cs_while_busy", 48'(phase), 48'd0);
            rom_a <= rom_addr[11:0];
            phase <= 1;
        end else if (phase == 1) begin
            phase <= 2;
        end else begin
            phase <= 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cs"},    48'(rom_cs),      48'd0);
        chk({tag, "_addr"},  48'(rom_addr),    48'h0000);
        chk({tag, "_valid"}, 48'(instr_valid), 48'd0);
        chk({tag, "_instr"}, {instr_pc, instr_word0, instr_word1}, 48'd0);
    endtask

    task automatic chk_instr(input string tag, input logic [15:0] p);
        logic [15:0] p1;
        p1 = p + 16'd1;
        chk(tag, {instr_pc, instr_word0, instr_word1}, {p, mem[p[11:0]], mem[p1[11:0]]});
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 48'(instr_valid), 48'd1);
    endtask

    initial begin
        int          n;
        int          cs_cnt;
        int          accepted;
        logic        after_redir;
        logic [15:0] exp_pc;

        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[0]      = 16'h0028;
        mem[1]      = 16'h000A;
        mem[2]      = 16'h0034;
        mem[3]      = 16'h7FFD;
        mem[12'h0C8] = 16'h0029;
        mem[12'h0C9] = 16'h000A;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // Reset values, then first two instructions back to back.
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) chk("first_cs", 48'({rom_cs, rom_addr}), 48'({1'b1, 16'h0000}));
            if (c == 7 || c == 13) chk("valid_at_7_13", 48'(instr_valid), 48'd1);
            else chk("valid_low", 48'(instr_valid), 48'd0);
            if (c == 7) chk_instr("instr_pc0", 16'h0000);
            if (c == 13) chk_instr("instr_pc2", 16'h0002);
        end

        // Redirect during the word1 WAIT_BUSY of pc=4.
        repeat (3) tick();
        chk("word1_cs_pc4", 48'({rom_cs, rom_addr}), 48'({1'b1, 16'h0005}));
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h00C8;
        tick();
        redirect_valid = 1'b0;
        chk("no_cs_during_discard", 48'(rom_cs), 48'd0);
        chk("flushed_after_redirect", 48'(instr_valid), 48'd0);
        tick();
        chk("redirect_cs", 48'({rom_cs, rom_addr}), 48'({1'b1, 16'h00C8}));
        wait_valid("redir_c8", 20);
        chk("redir_c8_cycle", 48'(cyc), 48'd25);
        chk_instr("instr_pc_c8", 16'h00C8);

        // Back-pressure: exactly two instructions fetched with instr_ready low.
        instr_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset("reset2");
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        cs_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (rom_cs) cs_cnt++;
        end
        chk("full_cs_count", 48'(cs_cnt), 48'd4);
        chk_instr("full_head_pc0", 16'h0000);
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("cs_after_pop", 48'({rom_cs, rom_addr}), 48'({1'b1, 16'h0004}));
        chk_instr("head_after_pop", 16'h0002);

        // Same-cycle pop and redirect with two entries queued.
        cs_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rom_cs) cs_cnt++;
        end
        chk("refill_cs_count", 48'(cs_cnt), 48'd1);
        chk_instr("head_before_redirect", 16'h0002);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        chk("pop_redirect_valid", 48'(instr_valid), 48'd0);
        chk("pop_redirect_cs", 48'({rom_cs, rom_addr}), 48'({1'b1, 16'h0010}));
        wait_valid("redir_10", 20);
        chk("redir_10_cycle", 48'(cyc), 48'd51);
        chk_instr("instr_pc_10", 16'h0010);

        // Reset asserted in the WAIT_DATA cycle of an in-flight fetch.
        n = 0;
        while (rom_cs !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("cs_before_mid_reset", 48'(rom_cs), 48'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_reset("mid_reset");
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        cs_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 3 && rom_cs) cs_cnt++;
            if (c == 1) chk("restart_cs", 48'({rom_cs, rom_addr}), 48'({1'b1, 16'h0000}));
        end
        chk("restart_single_cs", 48'(cs_cnt), 48'd1);
        chk("restart_valid7", 48'(instr_valid), 48'd1);
        chk_instr("restart_pc0", 16'h0000);

        // Redirect to the top of the address space wraps to zero.
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        wait_valid("wrap", 30);
        chk_instr("wrap_ffff", 16'hFFFF);
        tick();
        wait_valid("wrap_next", 30);
        chk_instr("wrap_0001", 16'h0001);

        // Randomized traffic against an in-order stream model.
        exp_pc      = 16'h0003;
        accepted    = 0;
        after_redir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = 16'($urandom);
            if (after_redir) chk("rand_flush", 48'(instr_valid), 48'd0);
            if (instr_valid) chk_instr("rand_instr", exp_pc);
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end else if (instr_valid && instr_ready) begin
                exp_pc = exp_pc + 16'd2;
                accepted++;
            end
            after_redir = redirect_valid;
        end
        redirect_valid = 1'b0;
        chk("rand_progress", 48'(accepted >= 50), 48'd1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
